// File: rtl/moving_avg_inverse_if.sv
// Sample-stream bundle between a moving-sum stage and its inverse.
// The master drives window sums and clear; the slave returns recovered samples and status.
interface moving_avg_inverse_if #(
  parameter int WIND_DEPTH = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int WIND_WIDTH = $clog2(WIND_DEPTH);
  localparam int MAVG_WIDTH = WIND_WIDTH + DATA_WIDTH;

  logic                  clear;
  logic [MAVG_WIDTH-1:0] s_N;
  logic                  s_N_valid;
  logic [DATA_WIDTH-1:0] x_N;
  logic                  x_N_valid;
  logic                  fill_done;
  logic                  range_err;

  modport master (
    output clear, s_N, s_N_valid,
    input  x_N, x_N_valid, fill_done, range_err
  );

  modport slave (
    input  clear, s_N, s_N_valid,
    output x_N, x_N_valid, fill_done, range_err
  );
endinterface

// File: rtl/moving_avg_inverse.sv
// Recovers x(n) from a running N-sample window sum: x(n) = s(n) - s(n-1) + x(n-N).
// One-cycle latency, sustains a new sample every cycle.
module moving_avg_inverse #(
  parameter int WIND_DEPTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  moving_avg_inverse_if.slave   bus
);
  localparam int WIND_WIDTH = $clog2(WIND_DEPTH);
  localparam int MAVG_WIDTH = WIND_WIDTH + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] hist_q [WIND_DEPTH];

  logic [WIND_WIDTH-1:0] wptr_q, wptr_d;
  logic [MAVG_WIDTH-1:0] s_prev_q, s_prev_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  x_valid_q, x_valid_d;
  logic                  fill_q, fill_d;
  logic                  range_err_q, range_err_d;

  logic [MAVG_WIDTH-1:0] hist_term;
  logic [MAVG_WIDTH-1:0] result;
  logic                  accept;

  always_comb begin
    accept      = bus.s_N_valid && !bus.clear;
    // Before the window has filled, the oldest sample has not been seen yet.
    hist_term   = fill_q ? {{WIND_WIDTH{1'b0}}, hist_q[wptr_q]} : '0;
    result      = bus.s_N - s_prev_q + hist_term;

    wptr_d      = wptr_q;
    s_prev_d    = s_prev_q;
    x_d         = x_q;
    x_valid_d   = 1'b0;
    fill_d      = fill_q;
    range_err_d = range_err_q;

    if (bus.clear) begin
      wptr_d      = '0;
      s_prev_d    = '0;
      fill_d      = 1'b0;
      range_err_d = 1'b0;
    end else if (bus.s_N_valid) begin
      wptr_d    = wptr_q + WIND_WIDTH'(1);
      s_prev_d  = bus.s_N;
      x_d       = result[DATA_WIDTH-1:0];
      x_valid_d = 1'b1;
      if (wptr_q == WIND_WIDTH'(WIND_DEPTH - 1)) fill_d = 1'b1;
      if (result[MAVG_WIDTH-1:DATA_WIDTH] != '0) range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      s_prev_q    <= '0;
      x_q         <= '0;
      x_valid_q   <= 1'b0;
      fill_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      s_prev_q    <= s_prev_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      fill_q      <= fill_d;
      range_err_q <= range_err_d;
    end
  end

  // Stale history is harmless: it is masked until the window refills.
  always_ff @(posedge clk) begin
    if (accept) hist_q[wptr_q] <= result[DATA_WIDTH-1:0];
  end

  assign bus.x_N       = x_q;
  assign bus.x_N_valid = x_valid_q;
  assign bus.fill_done = fill_q;
  assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_moving_avg_inverse.sv
// Directed bench for moving_avg_inverse with N=4, DATA_WIDTH=8 (MAVG_WIDTH=10).
module tb_moving_avg_inverse;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  moving_avg_inverse_if #(.WIND_DEPTH(4), .DATA_WIDTH(8)) bus ();

  moving_avg_inverse #(.WIND_DEPTH(4), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic step(input logic vld, input int s, input logic clr);
    @(negedge clk);
    bus.s_N_valid = vld;
    bus.s_N       = 10'(s);
    bus.clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int x, input int v, input int f, input int r);
    chk({tag, ".x_N"},       int'(bus.x_N),       x);
    chk({tag, ".x_N_valid"}, int'(bus.x_N_valid), v);
    chk({tag, ".fill_done"}, int'(bus.fill_done), f);
    chk({tag, ".range_err"}, int'(bus.range_err), r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.s_N_valid = 1'b0;
    bus.clear     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.clear = 1'b0;
    bus.s_N = '0;
    bus.s_N_valid = 1'b0;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    do_reset();

    // Fill sequence, back-to-back samples
    step(1'b1, 10, 1'b0);  chk_out("fill1", 10, 1, 0, 0);
    step(1'b1, 30, 1'b0);  chk_out("fill2", 20, 1, 0, 0);
    step(1'b1, 60, 1'b0);  chk_out("fill3", 30, 1, 0, 0);
    step(1'b1, 100, 1'b0); chk_out("fill4", 40, 1, 1, 0);
    step(1'b1, 140, 1'b0); chk_out("fill5", 50, 1, 1, 0);
    step(1'b1, 170, 1'b0); chk_out("hist_wrap", 50, 1, 1, 0);

    // Gap: strobe drops, x_N holds, state untouched
    step(1'b0, 999, 1'b0); chk_out("gap", 50, 0, 1, 0);
    step(1'b1, 200, 1'b0); chk_out("after_gap", 60, 1, 1, 0);

    // Clear with a simultaneous sample: sample discarded
    step(1'b1, 999, 1'b1); chk_out("clear_win", 60, 0, 0, 0);
    step(1'b1, 7, 1'b0);   chk_out("post_clear", 7, 1, 0, 0);

    // Out-of-range result, sticky error
    do_reset();
    step(1'b1, 300, 1'b0); chk_out("range1", 44, 1, 0, 1);
    step(1'b1, 310, 1'b0); chk_out("range_sticky", 10, 1, 0, 1);
    step(1'b0, 0, 1'b1);   chk_out("range_clear", 10, 0, 0, 0);

    // Modular wrap: s_prev=1000 then 5 -> 29
    do_reset();
    step(1'b1, 1000, 1'b0); chk_out("wrap_a", 232, 1, 0, 1);
    step(1'b1, 5, 1'b0);    chk_out("wrap_b", 29, 1, 0, 1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b0);    chk_out("wrap_c", 5, 1, 0, 0);

    // Asynchronous reset mid-stream
    do_reset();
    step(1'b1, 10, 1'b0); chk_out("mid1", 10, 1, 0, 0);
    step(1'b1, 30, 1'b0); chk_out("mid2", 20, 1, 0, 0);
    @(negedge clk);
    bus.s_N_valid = 1'b1;
    bus.s_N = 10'd60;
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.s_N_valid = 1'b0;
    step(1'b1, 10, 1'b0); chk_out("restart", 10, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/moving_avg_inverse.md
MOVING_AVG_INVERSE -- requirements
Module: moving_avg_inverse

Interface
REQ-001 Parameter WIND_DEPTH, default 16, window length N of the upstream moving-sum stage; power of two, >= 2.
REQ-002 Parameter DATA_WIDTH, default 16, width of recovered samples.
REQ-003 Derived WIND_WIDTH = clog2(WIND_DEPTH); MAVG_WIDTH = WIND_WIDTH + DATA_WIDTH.
REQ-004 clk  input  1  single clock; all state rises on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous flush of history and state.
REQ-007 s_N  input  MAVG_WIDTH  unsigned running window sum s(n) = SUM of the last N samples.
REQ-008 s_N_valid  input  1  s_N is a new sample this cycle.
REQ-009 x_N  output  DATA_WIDTH  recovered sample x(n).
REQ-010 x_N_valid  output  1  single-cycle strobe qualifying x_N.
REQ-011 fill_done  output  1  high once N samples have been recovered since reset/clear.
REQ-012 range_err  output  1  sticky; a recovered value exceeded DATA_WIDTH.

Function
REQ-013 The block SHALL compute x(n) = s(n) - s(n-1) + x(n-N), all terms MAVG_WIDTH wide, modulo 2^MAVG_WIDTH.
REQ-014 s(n-1) SHALL be held in a register s_prev, loaded with s_N on every accepted s_N_valid; value 0 after reset/clear.
REQ-015 x(n-N) SHALL come from an N-entry DATA_WIDTH history buffer indexed by write pointer wptr (0..N-1), read combinationally at wptr before overwrite.
REQ-016 While fill_done is 0, the x(n-N) term SHALL be forced to 0.
REQ-017 On s_N_valid, the low DATA_WIDTH bits of the result SHALL be written to history[wptr] and wptr SHALL advance, wrapping N-1 -> 0.
REQ-018 fill_done SHALL rise on the edge at which wptr wraps N-1 -> 0 for the first time, and stay high until reset/clear.
REQ-019 x_N and x_N_valid SHALL be registered: x_N_valid is high exactly one cycle after each accepted s_N_valid, low otherwise; x_N holds its value when x_N_valid is low.
REQ-020 Latency SHALL be 1 cycle; back-to-back s_N_valid on every cycle SHALL be sustained with no bubbles.
REQ-021 If any of the upper WIND_WIDTH bits of the result is nonzero, range_err SHALL set and remain set; x_N SHALL carry the low DATA_WIDTH bits (no saturation).
REQ-022 clear SHALL zero wptr, s_prev, fill_done, range_err and x_N_valid on the next edge; history contents need not be cleared (masked by REQ-016).
REQ-023 clear and s_N_valid in the same cycle: clear SHALL win, the sample SHALL be discarded, and x_N_valid SHALL be 0 the next cycle.
REQ-024 Gaps in s_N_valid SHALL NOT alter state; the recursion continues from the last accepted sample.

Reset
REQ-025 While reset is high: x_N = 0, x_N_valid = 0, fill_done = 0, range_err = 0, wptr = 0, s_prev = 0, applied asynchronously.
REQ-026 Reset asserted mid-stream SHALL discard any in-flight sample; the first post-reset output treats the history as empty.
REQ-027 Reset deassertion SHALL be safe relative to clk (the output must not go undefined); the first s_N_valid is accepted no earlier than the first edge after deassertion.

Verification (N=4, DATA_WIDTH=8, MAVG_WIDTH=10)
REQ-028 s_N = 10,30,60,100,140 on consecutive cycles -> x_N = 10,20,30,40,50 on consecutive cycles, each 1 cycle later; fill_done rises after the 4th sample.
REQ-029 After fill, s_prev=140, history=[50,20,30,40] with wptr=1; s_N=170 -> x_N = 170-140+20 = 50.
REQ-030 From reset, s_N=300 -> x_N=44, range_err=1 and remains 1 through later in-range samples until clear.
REQ-031 s_prev=1000, s_N=5 before fill -> x_N = (5-1000) mod 1024 = 29, range_err stays 0.
REQ-032 clear with s_N_valid on the same cycle mid-stream -> no x_N_valid next cycle, fill_done=0; the next sample s_N=7 yields x_N=7.
REQ-033 Reset pulse between samples 2 and 3 of REQ-028 -> all outputs 0 during reset; restarting with s_N=10 yields x_N=10.
